// File: rtl/speed_pkg.sv
// Shared types and constants for the wheel-speed sampler and its BCD converter.
package speed_pkg;

  typedef enum logic [2:0] {
    StCount,
    StLatch,
    StConvL,
    StConvR,
    StUpdate
  } state_e;

  localparam logic [7:0]  BCD_PAD      = 8'hFF;
  localparam logic [7:0]  SAT_LIMIT    = 8'd99;
  localparam int unsigned CONV_LATENCY = 9;

  // One double-dabble step on {hundreds[1:0], tens, ones, bin[7:0]}: add-3 then shift.
  function automatic logic [17:0] dabble_step(input logic [17:0] sr);
    logic [17:0] t;
    t = sr;
    if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[16:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial 8-bit binary to BCD converter (shift-add-3); conv_done pulses a fixed
// CONV_LATENCY cycles after an accepted conv_start.
module bcd_serial_conv
  import speed_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       conv_start,
  input  logic [7:0] conv_in,
  output logic       conv_done,
  output logic [9:0] bcd_out
);

  localparam logic [2:0] LastStep = 3'(CONV_LATENCY - 2);

  logic [17:0] sr_q, sr_d;
  logic [2:0]  step_q, step_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [9:0]  bcd_q, bcd_d;

  always_comb begin
    sr_d     = sr_q;
    step_d   = step_q;
    active_d = active_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    if (conv_start && !active_q) begin
      sr_d     = {10'd0, conv_in};
      step_d   = 3'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      sr_d   = dabble_step(sr_q);
      step_d = step_q + 3'd1;
      if (step_q == LastStep) begin
        active_d = 1'b0;
        done_d   = 1'b1;
        bcd_d    = sr_d[17:8];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sr_q     <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      sr_q     <= sr_d;
      step_q   <= step_d;
      active_q <= active_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
    end
  end

  assign conv_done = done_q;
  assign bcd_out   = bcd_q;

endmodule

// File: rtl/speed_sample_sched.sv
// Wheel-speed gate-window sampler: counts synchronised pulse edges per wheel and
// publishes BCD results. Optional clamp to 99 when SPEED_SAT_EN is defined.
module speed_sample_sched
  import speed_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 10_000_000,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  speed_pulse,
  output logic [31:0] speed_data,
  output logic [3:0]  hundreds,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned    GateW    = $clog2(GATE_CYCLES);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0]                  prev_q;
  logic [1:0]                  pulse_edge;
  logic [GateW-1:0]            gate_q, gate_d;
  logic                        gate_tc;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0][7:0]             conv_val;
  logic [1:0][7:0]             latch_q, latch_d;
  logic                        conv_start_q, conv_start_d;
  logic [7:0]                  conv_in_q, conv_in_d;
  logic                        conv_done;
  logic [9:0]                  bcd_out;
  logic [9:0]                  left_bcd_q, left_bcd_d;
  logic [31:0]                 speed_data_q, speed_data_d;
  logic [3:0]                  hundreds_q, hundreds_d;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], speed_pulse};
  assign pulse_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign gate_tc    = enable && (gate_q == GateLast);

  always_comb begin
    if (!enable || gate_tc) gate_d = '0;
    else                    gate_d = gate_q + GateW'(1);
  end

  // An edge on the terminal cycle belongs to the new window.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (!enable)                                   cnt_d[i] = '0;
      else if (gate_tc)                              cnt_d[i] = pulse_edge[i] ? CNT_W'(1) : '0;
      else if (pulse_edge[i] && cnt_q[i] != CntMax)  cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else                                           cnt_d[i] = cnt_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      conv_val[i] = cnt_q[i][8:1];
`ifdef SPEED_SAT_EN
      if (cnt_q[i][CNT_W-1:1] > (CNT_W-1)'(SAT_LIMIT)) conv_val[i] = SAT_LIMIT;
`endif
    end
  end

  assign latch_d = gate_tc ? conv_val : latch_q;

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_n) state_q <= StCount;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCount:  if (gate_tc) state_d = StLatch;
      StLatch:  state_d = StConvL;
      StConvL:  if (conv_done) state_d = StConvR;
      StConvR:  if (conv_done) state_d = StUpdate;
      StUpdate: state_d = StCount;
      default:  state_d = StCount;
    endcase
  end

  always_comb begin
    conv_start_d = 1'b0;
    conv_in_d    = conv_in_q;
    busy         = (state_q != StCount);
    data_valid   = (state_q == StUpdate);
    unique case (state_q)
      StLatch: begin
        conv_start_d = 1'b1;
        conv_in_d    = latch_q[1];
      end
      StConvL: begin
        if (conv_done) begin
          conv_start_d = 1'b1;
          conv_in_d    = latch_q[0];
        end
      end
      default: ;
    endcase
  end

  // Published words are loaded as UPDATE is entered so they line up with data_valid.
  always_comb begin
    left_bcd_d   = left_bcd_q;
    speed_data_d = speed_data_q;
    hundreds_d   = hundreds_q;
    if (state_q == StConvL && conv_done) left_bcd_d = bcd_out;
    if (state_q == StConvR && conv_done) begin
      speed_data_d = {BCD_PAD, left_bcd_q[7:0], BCD_PAD, bcd_out[7:0]};
      hundreds_d   = {left_bcd_q[9:8], bcd_out[9:8]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q       <= '0;
      prev_q       <= '0;
      gate_q       <= '0;
      cnt_q        <= '0;
      latch_q      <= '0;
      conv_start_q <= 1'b0;
      conv_in_q    <= '0;
      left_bcd_q   <= '0;
      speed_data_q <= {BCD_PAD, 8'h00, BCD_PAD, 8'h00};
      hundreds_q   <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= sync_q[SYNC_STAGES-1];
      gate_q       <= gate_d;
      cnt_q        <= cnt_d;
      latch_q      <= latch_d;
      conv_start_q <= conv_start_d;
      conv_in_q    <= conv_in_d;
      left_bcd_q   <= left_bcd_d;
      speed_data_q <= speed_data_d;
      hundreds_q   <= hundreds_d;
    end
  end

  bcd_serial_conv u_conv (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .conv_start (conv_start_q),
    .conv_in    (conv_in_q),
    .conv_done  (conv_done),
    .bcd_out    (bcd_out)
  );

  assign speed_data = speed_data_q;
  assign hundreds   = hundreds_q;

endmodule

// File: tb/tb_speed_sample_sched.sv
// Scoreboard bench: two instances (100- and 600-cycle windows) driven from pulse plans.
module tb_speed_sample_sched;

  localparam int R       = 5;
  localparam int PlanLen = 1200;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  h;
    int          c;
  } exp_t;

  logic        clk;
  logic        rst_n, rst_n_b, enable, enable_b;
  logic [1:0]  pulse_a, pulse_b;
  logic [31:0] sd_a, sd_b;
  logic [3:0]  h_a, h_b;
  logic        dv_a, dv_b, busy_a, busy_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   plan_al[PlanLen];
  bit   plan_ar[PlanLen];
  bit   plan_bl[PlanLen];

  speed_sample_sched #(.GATE_CYCLES(100), .CNT_W(12), .SYNC_STAGES(2)) u_dut_a (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .speed_pulse (pulse_a),
    .speed_data  (sd_a),
    .hundreds    (h_a),
    .data_valid  (dv_a),
    .busy        (busy_a)
  );

  speed_sample_sched #(.GATE_CYCLES(600), .CNT_W(12), .SYNC_STAGES(2)) u_dut_b (
    .clk_in      (clk),
    .rst_n       (rst_n_b),
    .enable      (enable_b),
    .speed_pulse (pulse_b),
    .speed_data  (sd_b),
    .hundreds    (h_b),
    .data_valid  (dv_b),
    .busy        (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // which: 0 = A left, 1 = A right, 2 = B left; one-cycle pulses every other cycle
  task automatic add_pulses(input int which, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       plan_al[start + 2 * i] = 1'b1;
        1:       plan_ar[start + 2 * i] = 1'b1;
        default: plan_bl[start + 2 * i] = 1'b1;
      endcase
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic [3:0] h, input int c);
    exp_t e;
    e.d = d; e.h = h; e.c = R + c;
    qa.push_back(e);
  endtask

  // Pulse driver: raw input for cycle cyc comes from the plan at offset cyc-R.
  initial begin
    int k;
    pulse_a = '0;
    pulse_b = '0;
    forever begin
      @(posedge clk);
      #1;
      k = cyc - R;
      if (k >= 0 && k < PlanLen) begin
        pulse_a = {plan_al[k], plan_ar[k]};
        pulse_b = {plan_bl[k], 1'b0};
      end else begin
        pulse_a = '0;
        pulse_b = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (dv_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_a at cycle %0d: got data %h", cyc, sd_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("valid_cycle_a", cyc, e.c);
        check("speed_data_a", sd_a, e.d);
        check("hundreds_a", {28'd0, h_a}, {28'd0, e.h});
      end
    end
  end

  always @(negedge clk) begin
    if (dv_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_b at cycle %0d: got data %h", cyc, sd_b);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("valid_cycle_b", cyc, e.c);
        check("speed_data_b", sd_b, e.d);
        check("hundreds_b", {28'd0, h_b}, {28'd0, e.h});
      end
    end
  end

  initial begin
    exp_t eb;
    rst_n    = 1'b0;
    rst_n_b  = 1'b0;
    enable   = 1'b1;
    enable_b = 1'b1;

    // Edge lands 2 cycles after the raw pulse; window w spans R+100w .. R+100w+99.
    add_pulses(0, 198, 50);   // window 2: 50 left
    add_pulses(1, 198, 20);   // window 2: 20 right
    add_pulses(0, 320, 6);    // window 3: 6 left
    add_pulses(0, 397, 1);    // edge on window-3 terminal cycle -> window 4
    add_pulses(0, 420, 1);    // window 4: one more left
    add_pulses(1, 510, 8);    // window 5: 8 right
    add_pulses(1, 650, 2);    // while disabled: must not count
    add_pulses(1, 710, 4);    // first window after re-enable
    add_pulses(0, 810, 10);   // window aborted by reset
    add_pulses(2, 0, 250);    // instance B: 250 left in one 600-cycle window

    push_a(32'hFF00_FF00, 4'h0, 121);
    push_a(32'hFF00_FF00, 4'h0, 221);
    push_a(32'hFF25_FF10, 4'h0, 321);
    push_a(32'hFF03_FF00, 4'h0, 421);
    push_a(32'hFF01_FF00, 4'h0, 521);
    push_a(32'hFF00_FF04, 4'h0, 621);
    push_a(32'hFF00_FF02, 4'h0, 821);
    push_a(32'hFF00_FF00, 4'h0, 1041);
`ifdef SPEED_SAT_EN
    eb.d = 32'hFF99_FF00; eb.h = 4'b0000;
`else
    eb.d = 32'hFF25_FF00; eb.h = 4'b0100;
`endif
    eb.c = R + 621;
    qb.push_back(eb);

    goto(R);
    check("reset_speed_data", sd_a, 32'hFF00_FF00);
    check("reset_hundreds", {28'd0, h_a}, 32'd0);
    check("reset_valid", {31'd0, dv_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_busy_b", {31'd0, busy_b}, 32'd0);
    rst_n   = 1'b1;
    rst_n_b = 1'b1;

    goto(R + 605);            // inside CONV_L of window 5
    check("busy_conv_l", {31'd0, busy_a}, 32'd1);
    enable = 1'b0;
    goto(R + 690);
    check("idle_busy", {31'd0, busy_a}, 32'd0);
    check("hold_speed_data", sd_a, 32'hFF00_FF04);
    goto(R + 700);
    enable = 1'b1;

    goto(R + 914);            // inside CONV_R
    check("busy_conv_r", {31'd0, busy_a}, 32'd1);
    check("pre_abort_data", sd_a, 32'hFF00_FF02);
    goto(R + 915);
    rst_n = 1'b0;
    goto(R + 916);
    check("abort_speed_data", sd_a, 32'hFF00_FF00);
    check("abort_hundreds", {28'd0, h_a}, 32'd0);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_valid", {31'd0, dv_a}, 32'd0);
    goto(R + 920);
    rst_n = 1'b1;

    goto(R + 1060);
    check("pending_a", qa.size(), 32'd0);
    check("pending_b", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
